// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver types and frame constants
package ps2_pkg;

   localparam int DATA_BITS = 8;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT = 1'b1;
   localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } ps2_state_t;

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - decoded scancode event bundle
interface ps2_kbd_rx_if;

   logic [7:0] code;
   logic       strobe;
   logic       err;

   modport master (output code, strobe, err);
   modport slave (input code, strobe, err);

endinterface

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - two-flop synchroniser plus run-length glitch filter
module ps2_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset_n_i,
   input  logic line,
   output logic level
);

   localparam int CNT_W = $clog2(FILTER_LEN + 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic [CNT_W-1:0] run_q;

   // Idle PS/2 level is high, so reset everything to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         run_q   <= '0;
      end else begin
         sync1_q <= line;
         sync2_q <= sync1_q;
         if (sync2_q == level_q) begin
            run_q <= '0;
         end else if (run_q == CNT_W'(FILTER_LEN - 1)) begin
            level_q <= sync2_q;
            run_q   <= '0;
         end else begin
            run_q <= run_q + 1'b1;
         end
      end
   end

   assign level = level_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard frame receiver with parity check and timeout
import ps2_pkg::*;

module ps2_kbd_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n_i,
   input  logic       ps2clk_i,
   input  logic       ps2data_i,
   output logic [7:0] code_o,
   output logic       strobe_o,
   output logic       err_o
);

   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic                 clk_f;
   logic                 data_f;
   logic                 clk_prev_q;
   logic                 fall;
   logic                 timeout;
   ps2_state_t           state_q, state_d;
   logic [7:0]           shift_q, shift_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 parity_ok_q, parity_ok_d;
   logic [TO_W-1:0]      tcnt_q;
   logic                 done_ok, done_err;
   logic [7:0]           code_q;
   logic                 strobe_q, err_q;

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk       (clk),
      .reset_n_i (reset_n_i),
      .line      (ps2clk_i),
      .level     (clk_f)
   );

   ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
      .clk       (clk),
      .reset_n_i (reset_n_i),
      .line      (ps2data_i),
      .level     (data_f)
   );

   assign fall    = clk_prev_q & ~clk_f;
   // A falling edge in the same cycle restarts the idle count, so it wins over timeout.
   assign timeout = (state_q != S_IDLE) && (tcnt_q == TO_W'(TIMEOUT_CYCLES)) && !fall;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      parity_ok_d = parity_ok_q;
      done_ok     = 1'b0;
      done_err    = 1'b0;
      if (timeout) begin
         state_d  = S_IDLE;
         done_err = 1'b1;
      end else if (fall) begin
         case (state_q)
            S_IDLE: begin
               if (data_f == START_BIT) begin
                  state_d   = S_DATA;
                  bit_cnt_d = '0;
               end
            end
            S_DATA: begin
               shift_d   = {data_f, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                  state_d = S_PARITY;
               end
            end
            S_PARITY: begin
               parity_ok_d = ^{shift_q, data_f};
               state_d     = S_STOP;
            end
            S_STOP: begin
               if ((data_f == STOP_BIT) && parity_ok_q) begin
                  done_ok = 1'b1;
               end else begin
                  done_err = 1'b1;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         parity_ok_q <= 1'b0;
         clk_prev_q  <= 1'b1;
         tcnt_q      <= '0;
         code_q      <= 8'h00;
         strobe_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         parity_ok_q <= parity_ok_d;
         clk_prev_q  <= clk_f;
         strobe_q    <= done_ok;
         err_q       <= done_err;
         if (done_ok) begin
            code_q <= shift_q;
         end
         if ((state_q == S_IDLE) || fall) begin
            tcnt_q <= '0;
         end else if (tcnt_q != TO_W'(TIMEOUT_CYCLES)) begin
            tcnt_q <= tcnt_q + 1'b1;
         end
      end
   end

   assign code_o   = code_q;
   assign strobe_o = strobe_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - directed table-driven bench for ps2_kbd_rx
module tb_ps2_kbd_rx;

   localparam int FL   = 8;
   localparam int TO   = 300;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ps2clk;
   logic       ps2data;
   logic [7:0] code_o;
   logic       strobe_o;
   logic       err_o;

   ps2_kbd_rx_if rx_if ();

   ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
      .clk       (clk),
      .reset_n_i (rst_n),
      .ps2clk_i  (ps2clk),
      .ps2data_i (ps2data),
      .code_o    (code_o),
      .strobe_o  (strobe_o),
      .err_o     (err_o)
   );

   assign rx_if.code   = code_o;
   assign rx_if.strobe = strobe_o;
   assign rx_if.err    = err_o;

   always #5 clk = ~clk;

   int tests = 0;
   int failed = 0;
   int n_strobe = 0;
   int n_err = 0;
   int n_both = 0;
   int n_wide = 0;
   logic strobe_prev = 1'b0;
   logic err_prev = 1'b0;

   always @(negedge clk) begin
      if (rx_if.strobe) n_strobe++;
      if (rx_if.err) n_err++;
      if (rx_if.strobe && rx_if.err) n_both++;
      if ((rx_if.strobe && strobe_prev) || (rx_if.err && err_prev)) n_wide++;
      strobe_prev = rx_if.strobe;
      err_prev    = rx_if.err;
   end

   typedef struct {
      logic [7:0] data;
      bit         pflip;
      bit         stopv;
      bit         glitch;
      int         exp_strobe;
      int         exp_err;
      logic [7:0] exp_code;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b, input bit glitch);
      wait_cycles(10);
      ps2data = b;
      wait_cycles(10);
      if (glitch) begin
         ps2clk = 1'b0;
         wait_cycles(FL - 1);
         ps2clk = 1'b1;
      end
      wait_cycles(20);
      ps2clk = 1'b0;
      if (glitch) begin
         wait_cycles(15);
         ps2clk = 1'b1;
         wait_cycles(FL - 1);
         ps2clk = 1'b0;
         wait_cycles(HALF - 15 - (FL - 1));
      end else begin
         wait_cycles(HALF);
      end
      ps2clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit pflip, input bit stopv,
                             input bit glitch, input int nbits);
      logic [10:0] fr;
      fr = {stopv, (~^d) ^ pflip, d, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(fr[i], glitch);
   endtask

   initial begin
      int s0, e0;
      vecs[0] = '{8'h1C, 0, 1, 0, 1, 0, 8'h1C};
      vecs[1] = '{8'hF0, 0, 1, 0, 1, 0, 8'hF0};
      vecs[2] = '{8'h1C, 0, 1, 0, 1, 0, 8'h1C};
      vecs[3] = '{8'h1C, 1, 1, 0, 0, 1, 8'h1C};
      vecs[4] = '{8'h5A, 0, 1, 0, 1, 0, 8'h5A};
      vecs[5] = '{8'h33, 0, 0, 0, 0, 1, 8'h5A};
      vecs[6] = '{8'h5A, 0, 1, 1, 1, 0, 8'h5A};
      vecs[7] = '{8'h00, 0, 1, 0, 1, 0, 8'h00};

      rst_n   = 1'b0;
      ps2clk  = 1'b1;
      ps2data = 1'b1;
      wait_cycles(5);
      check("reset_code", code_o, 8'h00);
      check("reset_strobe", strobe_o, 1'b0);
      check("reset_err", err_o, 1'b0);
      rst_n = 1'b1;
      wait_cycles(20);

      for (int i = 0; i < 8; i++) begin
         s0 = n_strobe;
         e0 = n_err;
         send_frame(vecs[i].data, vecs[i].pflip, vecs[i].stopv, vecs[i].glitch, 11);
         wait_cycles(60);
         check($sformatf("vec%0d_strobes", i), n_strobe - s0, vecs[i].exp_strobe);
         check($sformatf("vec%0d_errs", i), n_err - e0, vecs[i].exp_err);
         check($sformatf("vec%0d_code", i), code_o, vecs[i].exp_code);
      end

      // Stop-bit edge to strobe latency: 2 sync + FL filter + 1 edge detect cycles.
      send_frame(8'h1C, 0, 1, 0, 10);
      wait_cycles(10);
      ps2data = 1'b1;
      wait_cycles(30);
      ps2clk = 1'b0;
      wait_cycles(10);
      check("lat_before", strobe_o, 1'b0);
      wait_cycles(1);
      check("lat_strobe", strobe_o, 1'b1);
      check("lat_code", code_o, 8'h1C);
      wait_cycles(1);
      check("lat_after", strobe_o, 1'b0);
      wait_cycles(HALF - 12);
      ps2clk = 1'b1;
      wait_cycles(60);

      // Partial frame abandoned by timeout.
      s0 = n_strobe;
      e0 = n_err;
      send_frame(8'hA5, 0, 1, 0, 5);
      wait_cycles(TO + 100);
      check("to_errs", n_err - e0, 1);
      check("to_strobes", n_strobe - s0, 0);
      send_frame(8'hF0, 0, 1, 0, 11);
      wait_cycles(60);
      check("to_next_code", code_o, 8'hF0);
      check("to_next_strobes", n_strobe - s0, 1);

      // Reset in the middle of a frame.
      s0 = n_strobe;
      e0 = n_err;
      send_frame(8'h6B, 0, 1, 0, 6);
      rst_n = 1'b0;
      wait_cycles(3);
      check("mid_rst_code", code_o, 8'h00);
      check("mid_rst_strobe", strobe_o, 1'b0);
      check("mid_rst_err", err_o, 1'b0);
      ps2data = 1'b1;
      rst_n   = 1'b1;
      wait_cycles(400);
      check("mid_rst_no_events", (n_strobe - s0) + (n_err - e0), 0);
      send_frame(8'h1C, 0, 1, 0, 11);
      wait_cycles(60);
      check("post_rst_code", code_o, 8'h1C);
      check("post_rst_strobes", n_strobe - s0, 1);

      check("strobe_err_overlap", n_both, 0);
      check("pulse_width", n_wide, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
